id_ex_stage: RTL

Decode-to-execute pipeline register for the 32-bit pipelined datapath. It captures decoded operands, the immediate, the ALU opcode and the destination register from the decode stage. It resolves data hazards by forwarding results from the EX/MEM and MEM/WB stages. It drives the ALU's `A`, `B` and `ALUOp` inputs directly. It also supports pipeline stall (hold) and flush (bubble insertion).

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/forward_unit.sv | 43 ++++
 rtl/id_ex_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the 32-bit pipelined datapath.
// Holds the ALU opcode encodings, the forwarding-select encodings and the
// default datapath / register-address widths used by the pipeline stages.
package pipeline_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int REG_AW_DEFAULT = 5;

  localparam logic [2:0] ALU_MOV  = 3'b000;
  localparam logic [2:0] ALU_NOT  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_NOR  = 3'b100;
  localparam logic [2:0] ALU_NAND = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// Combinational forwarding-select logic for the execute stage.
// Ports:
//   valid                             execute stage holds a valid instruction
//   rs1, rs2                          registered source register addresses
//   exmem_rd, exmem_reg_write         EX/MEM destination and write enable
//   memwb_rd, memwb_reg_write         MEM/WB destination and write enable
//   fwd_a, fwd_b                      select for operand A / rs2 value
module forward_unit
  import pipeline_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              valid,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  // The younger result (EX/MEM) takes priority; r0 is hard-wired zero and
  // must never be replaced by a forwarded value.
  function automatic logic [1:0] pick(input logic [REG_AW-1:0] rs);
    logic [1:0] sel;
    sel = FWD_REG;
    if (valid) begin
      if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs))
        sel = FWD_EXMEM;
      else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs))
        sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = pick(rs1);
    fwd_b = pick(rs2);
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with operand forwarding.
// Captures the decoded instruction, supports stall (hold) and flush (bubble),
// and drives the ALU operands after EX/MEM and MEM/WB forwarding.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   id_*                             decode-stage instruction fields
//   stall, flush                     hold / bubble control (flush wins)
//   exmem_*, memwb_*                 forwarding sources
//   ex_valid, alu_a, alu_b, alu_op   execute-stage ALU drive
//   ex_rd, ex_reg_write              registered destination and write enable
//   ex_fwd_a, ex_fwd_b               forwarding selects (debug visibility)
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [2:0]        id_alu_op,
  input  logic              id_data_s,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b
);

  logic              vld_p1;
  logic              rw_p1;
  logic [2:0]        op_p1;
  logic [DATA_W-1:0] rd1_p1;
  logic [DATA_W-1:0] rd2_p1;
  logic [DATA_W-1:0] imm_p1;
  logic              data_s_p1;
  logic [REG_AW-1:0] rs1_p1;
  logic [REG_AW-1:0] rs2_p1;
  logic [REG_AW-1:0] rd_p1;

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      rw_p1     <= 1'b0;
      op_p1     <= ALU_MOV;
      rd1_p1    <= '0;
      rd2_p1    <= '0;
      imm_p1    <= '0;
      data_s_p1 <= 1'b0;
      rs1_p1    <= '0;
      rs2_p1    <= '0;
      rd_p1     <= '0;
    end else if (flush) begin
      vld_p1    <= 1'b0;
      rw_p1     <= 1'b0;
      op_p1     <= ALU_MOV;
      rd1_p1    <= '0;
      rd2_p1    <= '0;
      imm_p1    <= '0;
      data_s_p1 <= 1'b0;
      rs1_p1    <= '0;
      rs2_p1    <= '0;
      rd_p1     <= '0;
    end else if (!stall) begin
      vld_p1    <= id_valid;
      rw_p1     <= id_reg_write & id_valid;
      op_p1     <= id_alu_op;
      rd1_p1    <= id_rd1;
      rd2_p1    <= id_rd2;
      imm_p1    <= id_imm;
      data_s_p1 <= id_data_s;
      rs1_p1    <= id_rs1;
      rs2_p1    <= id_rs2;
      rd_p1     <= id_rd;
    end
  end

  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  forward_unit #(.REG_AW(REG_AW)) u_fwd (
    .valid           (vld_p1),
    .rs1             (rs1_p1),
    .rs2             (rs2_p1),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  // ---- EX operand selection (combinational) ----
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] rs2_val;

  always_comb begin
    unique case (fwd_a)
      FWD_EXMEM: opa = exmem_result;
      FWD_MEMWB: opa = memwb_result;
      default:   opa = rd1_p1;
    endcase
    unique case (fwd_b)
      FWD_EXMEM: rs2_val = exmem_result;
      FWD_MEMWB: rs2_val = memwb_result;
      default:   rs2_val = rd2_p1;
    endcase

    // An invalid slot presents a clean bubble to the ALU, even when it was
    // captured (id_valid low) rather than flushed in.
    ex_valid     = vld_p1;
    ex_reg_write = rw_p1 & vld_p1;
    ex_rd        = rd_p1;
    ex_fwd_a     = fwd_a;
    ex_fwd_b     = fwd_b;
    alu_a        = vld_p1 ? opa : '0;
    alu_b        = vld_p1 ? (data_s_p1 ? imm_p1 : rs2_val) : '0;
    alu_op       = vld_p1 ? op_p1 : ALU_MOV;
  end

endmodule
